// File: rtl/led_blink_pkg.sv
// ============================================================================
// Module      : led_blink_pkg
// Description : Shared mode encoding and index-width helper for the LED blinker.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package led_blink_pkg;

    typedef enum logic [1:0] {
        LED_OFF   = 2'd0,
        LED_ON    = 2'd1,
        LED_BLINK = 2'd2,
        LED_BURST = 2'd3
    } led_mode_t;

    localparam int c_CH_IDX_MIN_W = 1;

    // A single channel still needs a one-bit index port.
    function automatic int ch_idx_w(input int num_ch);
        return ($clog2(num_ch) > c_CH_IDX_MIN_W) ? $clog2(num_ch) : c_CH_IDX_MIN_W;
    endfunction

endpackage

`default_nettype wire

// File: rtl/led_blink_chan.sv
// ============================================================================
// Module      : led_blink_chan
// Description : One LED channel: mode FSM, half-period counter, burst counter.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module led_blink_chan
    import led_blink_pkg::*;
#(
    parameter int CNT_WIDTH   = 24,
    parameter int BURST_WIDTH = 8
) (
    input  logic                   i_Clk,
    input  logic                   i_Rst_L,
    input  logic                   i_Wr,
    input  logic [1:0]             i_Mode,
    input  logic [CNT_WIDTH-1:0]   i_Half_Period,
    input  logic [BURST_WIDTH-1:0] i_Burst,
    input  logic                   i_Sync,
    output logic                   o_LED,
    output logic                   o_Busy
);

    localparam logic [CNT_WIDTH-1:0]   c_CNT_ONE   = CNT_WIDTH'(1);
    localparam logic [BURST_WIDTH-1:0] c_BURST_ONE = BURST_WIDTH'(1);

    led_mode_t              mode_q, mode_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0]   half_q, half_d;
    logic [BURST_WIDTH-1:0] rem_q, rem_d;
    logic                   led_q, led_d;

    logic [CNT_WIDTH-1:0]   w_h_eff;
    logic                   w_terminal;
    logic                   w_running;

    always_comb begin
        w_h_eff    = (half_q == '0) ? c_CNT_ONE : half_q;
        w_terminal = (cnt_q == (w_h_eff - c_CNT_ONE));
        w_running  = (mode_q == LED_BLINK) || (mode_q == LED_BURST);
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            mode_q <= LED_OFF;
            cnt_q  <= '0;
            half_q <= c_CNT_ONE;
            rem_q  <= '0;
            led_q  <= 1'b0;
        end else begin
            mode_q <= mode_d;
            cnt_q  <= cnt_d;
            half_q <= half_d;
            rem_q  <= rem_d;
            led_q  <= led_d;
        end
    end

    // Priority: config write, then sync, then free-running phase timing.
    always_comb begin
        mode_d = mode_q;
        cnt_d  = cnt_q;
        half_d = half_q;
        rem_d  = rem_q;
        led_d  = led_q;
        if (i_Wr) begin
            cnt_d  = '0;
            half_d = i_Half_Period;
            rem_d  = '0;
            case (led_mode_t'(i_Mode))
                LED_OFF: begin
                    mode_d = LED_OFF;
                    led_d  = 1'b0;
                end
                LED_ON: begin
                    mode_d = LED_ON;
                    led_d  = 1'b1;
                end
                LED_BLINK: begin
                    mode_d = LED_BLINK;
                    led_d  = 1'b1;
                end
                default: begin
                    if (i_Burst != '0) begin
                        mode_d = LED_BURST;
                        led_d  = 1'b1;
                        rem_d  = i_Burst;
                    end else begin
                        mode_d = LED_OFF;
                        led_d  = 1'b0;
                    end
                end
            endcase
        end else if (i_Sync && w_running) begin
            cnt_d = '0;
            led_d = 1'b1;
        end else if (w_running) begin
            if (w_terminal) begin
                cnt_d = '0;
                led_d = ~led_q;
                // A burst pulse completes on each falling toggle.
                if ((mode_q == LED_BURST) && led_q) begin
                    rem_d = rem_q - c_BURST_ONE;
                    if (rem_q == c_BURST_ONE) begin
                        mode_d = LED_OFF;
                        led_d  = 1'b0;
                    end
                end
            end else begin
                cnt_d = cnt_q + c_CNT_ONE;
            end
        end else begin
            cnt_d = '0;
        end
    end

    assign o_LED  = led_q;
    assign o_Busy = (mode_q == LED_BURST);

endmodule

`default_nettype wire

// File: rtl/led_blink_multi.sv
// ============================================================================
// Module      : led_blink_multi
// Description : NUM_CH-channel LED blinker with a shared config write port.
//               Define LED_BLINK_SYNC_EN to add the i_Sync phase-align input.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module led_blink_multi
    import led_blink_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int CNT_WIDTH   = 24,
    parameter int BURST_WIDTH = 8
) (
    input  logic                          i_Clk,
    input  logic                          i_Rst_L,
    input  logic                          i_Cfg_Wr,
    input  logic [ch_idx_w(NUM_CH)-1:0]   i_Cfg_Ch,
    input  logic [1:0]                    i_Cfg_Mode,
    input  logic [CNT_WIDTH-1:0]          i_Cfg_Half_Period,
    input  logic [BURST_WIDTH-1:0]        i_Cfg_Burst,
`ifdef LED_BLINK_SYNC_EN
    input  logic                          i_Sync,
`endif
    output logic [NUM_CH-1:0]             o_LED,
    output logic [NUM_CH-1:0]             o_Busy
);

    localparam int CH_W = ch_idx_w(NUM_CH);

    logic w_sync;

`ifdef LED_BLINK_SYNC_EN
    assign w_sync = i_Sync;
`else
    assign w_sync = 1'b0;
`endif

    // Indices at or above NUM_CH match no instance, so such writes are dropped.
    for (genvar n = 0; n < NUM_CH; n++) begin : g_chan
        logic w_wr;
        assign w_wr = i_Cfg_Wr && (i_Cfg_Ch == CH_W'(n));

        led_blink_chan #(
            .CNT_WIDTH   (CNT_WIDTH),
            .BURST_WIDTH (BURST_WIDTH)
        ) u_chan (
            .i_Clk         (i_Clk),
            .i_Rst_L       (i_Rst_L),
            .i_Wr          (w_wr),
            .i_Mode        (i_Cfg_Mode),
            .i_Half_Period (i_Cfg_Half_Period),
            .i_Burst       (i_Cfg_Burst),
            .i_Sync        (w_sync),
            .o_LED         (o_LED[n]),
            .o_Busy        (o_Busy[n])
        );
    end

endmodule

`default_nettype wire

// File: tb/tb_led_blink_multi.sv
// ============================================================================
// Module      : tb_led_blink_multi
// Description : Directed bench; a 4-channel and a 3-channel instance share one
//               config bus so index 3 is out of range for the smaller one.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_led_blink_multi;

    logic        clk;
    logic        rst_n;
    logic        cfg_wr;
    logic [1:0]  cfg_ch;
    logic [1:0]  cfg_mode;
    logic [23:0] cfg_half;
    logic [7:0]  cfg_burst;
    logic        sync;
    logic [3:0]  led4, busy4;
    logic [2:0]  led3, busy3;

    int n_cmp = 0;
    int n_err = 0;
    logic chk_en = 1'b0;

    // Model state per channel: mode, effective half-period, pulses left, elapsed clocks.
    int mm [4];
    int mh [4];
    int mn [4];
    int mt [4];

    led_blink_multi #(.NUM_CH(4), .CNT_WIDTH(24), .BURST_WIDTH(8)) u_dut4 (
        .i_Clk(clk), .i_Rst_L(rst_n), .i_Cfg_Wr(cfg_wr), .i_Cfg_Ch(cfg_ch),
        .i_Cfg_Mode(cfg_mode), .i_Cfg_Half_Period(cfg_half), .i_Cfg_Burst(cfg_burst),
`ifdef LED_BLINK_SYNC_EN
        .i_Sync(sync),
`endif
        .o_LED(led4), .o_Busy(busy4)
    );

    led_blink_multi #(.NUM_CH(3), .CNT_WIDTH(24), .BURST_WIDTH(8)) u_dut3 (
        .i_Clk(clk), .i_Rst_L(rst_n), .i_Cfg_Wr(cfg_wr), .i_Cfg_Ch(cfg_ch),
        .i_Cfg_Mode(cfg_mode), .i_Cfg_Half_Period(cfg_half), .i_Cfg_Burst(cfg_burst),
`ifdef LED_BLINK_SYNC_EN
        .i_Sync(sync),
`endif
        .o_LED(led3), .o_Busy(busy3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // LED on during even-numbered phases since the last restart.
    function automatic logic mled(input int i);
        if (mm[i] == 0) return 1'b0;
        if (mm[i] == 1) return 1'b1;
        return ((mt[i] / mh[i]) % 2) == 0;
    endfunction

    function automatic logic [3:0] exp_led();
        logic [3:0] v;
        for (int i = 0; i < 4; i++) v[i] = mled(i);
        return v;
    endfunction

    function automatic logic [3:0] exp_busy();
        logic [3:0] v;
        for (int i = 0; i < 4; i++) v[i] = (mm[i] == 3);
        return v;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                mm[i] = 0; mh[i] = 1; mn[i] = 0; mt[i] = 0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (cfg_wr && (int'(cfg_ch) == i)) begin
                    mt[i] = 0;
                    mh[i] = (cfg_half == 24'd0) ? 1 : int'(cfg_half);
                    mn[i] = int'(cfg_burst);
                    if (cfg_mode == 2'd3) mm[i] = (cfg_burst == 8'd0) ? 0 : 3;
                    else mm[i] = int'(cfg_mode);
                end else if (sync && mm[i] >= 2) begin
                    // Pulses already finished are those whose falling edge has passed.
                    if (mm[i] == 3) mn[i] = mn[i] - (mt[i] + mh[i]) / (2 * mh[i]);
                    mt[i] = 0;
                end else if (mm[i] >= 2) begin
                    mt[i] = mt[i] + 1;
                    if (mm[i] == 3 && mt[i] >= (2 * mn[i] - 1) * mh[i]) mm[i] = 0;
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            logic [3:0] el, eb;
            el = exp_led();
            eb = exp_busy();
            chk("led4", {28'd0, led4}, {28'd0, el});
            chk("busy4", {28'd0, busy4}, {28'd0, eb});
            chk("led3", {29'd0, led3}, {29'd0, el[2:0]});
            chk("busy3", {29'd0, busy3}, {29'd0, eb[2:0]});
        end
    end

    task automatic wr(input logic [1:0] ch, input logic [1:0] mode, input int h, input int b);
        cfg_wr    = 1'b1;
        cfg_ch    = ch;
        cfg_mode  = mode;
        cfg_half  = h[23:0];
        cfg_burst = b[7:0];
        @(negedge clk);
        cfg_wr    = 1'b0;
    endtask

    initial begin
        logic [11:0] pat;
        rst_n = 1'b0; cfg_wr = 1'b0; cfg_ch = '0; cfg_mode = '0;
        cfg_half = '0; cfg_burst = '0; sync = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_led", {28'd0, led4}, 32'd0);
        chk("rst_busy", {28'd0, busy4}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk_en = 1'b1;

        // ch0 BLINK, half-period 3
        wr(2'd0, 2'd2, 3, 0);
        pat = 12'b111000111000;
        for (int k = 0; k < 12; k++) begin
            chk("blink0", {31'd0, led4[0]}, {31'd0, pat[11-k]});
            chk("blink0_model", {31'd0, mled(0)}, {31'd0, pat[11-k]});
            @(negedge clk);
        end

        // ch1 BURST, half-period 2, three pulses
        wr(2'd1, 2'd3, 2, 3);
        pat = 12'b110011001100;
        for (int k = 0; k < 12; k++) begin
            chk("burst1_led", {31'd0, led4[1]}, {31'd0, pat[11-k]});
            chk("burst1_busy", {31'd0, busy4[1]}, {31'd0, (k < 10) ? 1'b1 : 1'b0});
            chk("burst1_model", {31'd0, mled(1)}, {31'd0, pat[11-k]});
            @(negedge clk);
        end

        // ch2 BURST with zero count, ch3 BLINK with half-period 0
        wr(2'd2, 2'd3, 5, 0);
        wr(2'd3, 2'd2, 0, 0);
        pat = 12'b101010101010;
        for (int k = 0; k < 6; k++) begin
            chk("blink3_h0", {31'd0, led4[3]}, {31'd0, pat[11-k]});
            chk("burst2_zero", {30'd0, led4[2], busy4[2]}, 32'd0);
            @(negedge clk);
        end

        // ON written on the very edge ch0's counter reaches terminal
        wr(2'd0, 2'd2, 3, 0);
        repeat (2) @(negedge clk);
        wr(2'd0, 2'd1, 3, 0);
        for (int k = 0; k < 4; k++) begin
            chk("collide_on", {31'd0, led4[0]}, 32'd1);
            @(negedge clk);
        end

        // Index 3 is out of range for the 3-channel instance
        wr(2'd3, 2'd1, 7, 0);
        repeat (3) @(negedge clk);
        chk("oob_led3", {29'd0, led3}, {29'd0, exp_led() & 4'b0111});

`ifdef LED_BLINK_SYNC_EN
        wr(2'd0, 2'd2, 4, 0);
        @(negedge clk);
        wr(2'd1, 2'd2, 4, 0);
        repeat (3) @(negedge clk);
        sync = 1'b1;
        @(negedge clk);
        sync = 1'b0;
        pat = 12'b111100001111;
        for (int k = 0; k < 12; k++) begin
            chk("sync_ch0", {31'd0, led4[0]}, {31'd0, pat[11-k]});
            chk("sync_ch1", {31'd0, led4[1]}, {31'd0, pat[11-k]});
            @(negedge clk);
        end
        // Burst: one pulse done before sync, two remain after it
        wr(2'd1, 2'd3, 2, 3);
        repeat (3) @(negedge clk);
        sync = 1'b1;
        @(negedge clk);
        sync = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk("sync_burst_busy", {31'd0, busy4[1]}, {31'd0, (k < 6) ? 1'b1 : 1'b0});
            @(negedge clk);
        end
`endif

        // Asynchronous reset in the middle of a burst
        wr(2'd1, 2'd3, 2, 5);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_led", {28'd0, led4}, 32'd0);
        chk("async_rst_busy", {28'd0, busy4}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("post_rst_led", {28'd0, led4}, 32'd0);
        chk("post_rst_busy", {28'd0, busy4}, 32'd0);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
